// File: rtl/step_pkg.sv
// step_pkg: shared state encoding, default timing constants and direction codes
package step_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_e;
  localparam int HALF_PERIOD_DEF = 25;
  localparam int SETUP_CYC_DEF = 5;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
  // width needed to hold the larger of two reload values
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/step_timer.sv
// step_timer: loadable down-counter that parks at zero and flags done there
module step_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  // reload on request, otherwise count down and hold at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns a step request level into a step/dir pulse train with setup time and position count
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int POS_W = 16
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             stepenable,
  input  logic             direct,
  input  logic             clr_pos,
  output logic             step_out,
  output logic             dir_out,
  output logic             ena_n,
  output logic [POS_W-1:0] pos,
  output logic             step_tick,
  output logic             busy
);
  localparam int CW = cnt_w(HALF_PERIOD, SETUP_CYC);
  localparam logic [CW-1:0] HP_LD = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] SU_LD = CW'(SETUP_CYC - 1);
  localparam logic [POS_W-1:0] ONE = POS_W'(1);
  state_e state_q;
  logic step_q, dir_q, ena_n_q, tick_q;
  logic [POS_W-1:0] pos_q, pos_d;
  logic tmr_load, tmr_done, step_tick_d;
  logic [CW-1:0] tmr_val;
  // the timer counts out setup, high and low phases; each phase reloads it when the previous one ends
  assign tmr_load = state_q == IDLE ? stepenable : tmr_done;
  assign tmr_val = (state_q == IDLE || (state_q == LOW && direct != dir_q)) ? SU_LD : HP_LD;
  step_timer #(.W(CW)) u_tmr (
    .clk(sclk),
    .rst(s_rst),
    .load_i(tmr_load),
    .val_i(tmr_val),
    .done_o(tmr_done)
  );
  // a step is issued on every edge that moves the FSM into HIGH; clear overrides the count
  always_comb begin
    step_tick_d = tmr_done && (state_q == SETUP ||
                  (state_q == LOW && stepenable && direct == dir_q));
    pos_d = clr_pos ? '0 : step_tick_d ? (dir_q == DIR_FWD ? pos_q + ONE : pos_q - ONE) : pos_q;
  end
  // control FSM with registered step/dir/enable outputs; dir only moves while step_out is low
  always_ff @(posedge sclk or posedge s_rst)
    if (s_rst) begin
      state_q <= IDLE;
      step_q <= 1'b0;
      dir_q <= 1'b0;
      ena_n_q <= 1'b1;
      tick_q <= 1'b0;
      pos_q <= '0;
    end else begin
      tick_q <= step_tick_d;
      pos_q <= pos_d;
      case (state_q)
        IDLE: if (stepenable) begin
          state_q <= SETUP;
          dir_q <= direct;
          ena_n_q <= 1'b0;
        end
        SETUP: if (tmr_done) begin
          state_q <= HIGH;
          step_q <= 1'b1;
        end
        HIGH: if (tmr_done) begin
          state_q <= LOW;
          step_q <= 1'b0;
        end
        LOW: if (tmr_done) begin
          if (!stepenable) begin
            state_q <= IDLE;
            ena_n_q <= 1'b1;
          end else if (direct != dir_q) begin
            state_q <= SETUP;
            dir_q <= direct;
          end else begin
            state_q <= HIGH;
            step_q <= 1'b1;
          end
        end
      endcase
    end
  assign step_out = step_q;
  assign dir_out = dir_q;
  assign ena_n = ena_n_q;
  assign pos = pos_q;
  assign step_tick = tick_q;
  assign busy = state_q != IDLE;
endmodule
